// File: rtl/instr_prefetch_unit.sv
// rtl/instr_prefetch_unit.sv - PC owner, fixed-latency imem reader and FWFT prefetch queue
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   load_pc, sel_pc          redirect strobe and source (00 head+4, 01 START_ADDR, 10 branch_target, 11 head)
//   branch_target            redirect byte address for sel_pc=10
//   imem_addr, imem_rd_en    word read request to instruction memory
//   imem_rdata               read data, valid MEM_LATENCY cycles after the request
//   instr_out, pc_out        head instruction and its PC (0 when empty)
//   instr_valid, instr_ready head handshake toward decode
//   fifo_count               occupied queue entries
module instr_prefetch_unit #(
  parameter logic [31:0] START_ADDR  = 32'h0000_0000,
  parameter int          DEPTH       = 4,
  parameter int          MEM_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_pc,
  input  logic [1:0]                 sel_pc,
  input  logic [31:0]                branch_target,
  output logic [31:0]                imem_addr,
  output logic                       imem_rd_en,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]            fetch_pc;
  logic [MEM_LATENCY-1:0] trk_v;
  logic [31:0]            trk_pc [MEM_LATENCY];
  logic [31:0]            q_instr [DEPTH];
  logic [31:0]            q_pc [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic [7:0]             inflight;
  logic                   empty;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [31:0]            base_pc;
  logic [31:0]            redirect_pc;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + {7'd0, trk_v[i]};
    end
  end

  assign empty = (count == '0);

  // Credit rule: every outstanding request already owns a queue slot, so the
  // queue can never be asked to accept a word it has no room for.
  assign issue = !rst && !load_pc && ((8'(count) + inflight) < 8'(DEPTH));
  assign push  = trk_v[MEM_LATENCY-1] && !load_pc;
  assign pop   = !empty && instr_ready && !load_pc;

  // Sequential-PC redirects fall back to fetch_pc when there is no head to use.
  always_comb begin
    base_pc = empty ? fetch_pc : q_pc[rd_ptr];
    case (sel_pc)
      2'b00:   redirect_pc = base_pc + 32'd4;
      2'b01:   redirect_pc = START_ADDR;
      2'b10:   redirect_pc = branch_target & 32'hFFFF_FFFC;
      default: redirect_pc = base_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= START_ADDR;
      trk_v    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // A redirect kills everything in flight; their data is dropped on return.
      trk_v[0] <= issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        trk_v[i] <= trk_v[i-1] && !load_pc;
      end
      if (load_pc) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: validity lives in trk_v and count.
  always_ff @(posedge clk) begin
    trk_pc[0] <= fetch_pc;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      trk_pc[i] <= trk_pc[i-1];
    end
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= trk_pc[MEM_LATENCY-1];
    end
  end

  assign imem_addr   = fetch_pc;
  assign imem_rd_en  = issue;
  assign instr_valid = !empty;
  assign instr_out   = empty ? 32'd0 : q_instr[rd_ptr];
  assign pc_out      = empty ? 32'd0 : q_pc[rd_ptr];
  assign fifo_count  = count;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb/tb_instr_prefetch_unit.sv - scoreboard bench for instr_prefetch_unit
module tb_instr_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam int          LAT   = 2;
  localparam logic [31:0] START = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_pc;
  logic [1:0]  sel_pc;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_prefetch_unit #(
    .START_ADDR (START),
    .DEPTH      (DEPTH),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_pc      (load_pc),
    .sel_pc       (sel_pc),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .fifo_count   (fifo_count)
  );

  // Instruction memory: word = address ^ KEY, returned LAT cycles after request.
  logic        mp_v [LAT];
  logic [31:0] mp_a [LAT];
  initial for (int i = 0; i < LAT; i++) begin mp_v[i] = 1'b0; mp_a[i] = '0; end
  always @(posedge clk) begin
    mp_v[0] <= imem_rd_en;
    mp_a[0] <= imem_addr;
    for (int i = 1; i < LAT; i++) begin
      mp_v[i] <= mp_v[i-1];
      mp_a[i] <= mp_a[i-1];
    end
  end
  assign imem_rdata = mp_v[LAT-1] ? (mp_a[LAT-1] ^ KEY) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of issued-but-unconsumed {pc, instr}, arrival
  // times of outstanding reads, and the number of words already returned.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  int          arr[$];
  int          mdl_count = 0;
  logic [31:0] mdl_fetch = START;
  int          cyc = 0;
  int          pops = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] base;
    logic [31:0] tgt;
    logic        exp_rd;
    cyc++;
    if (rst) begin
      chk("rd_en_in_reset", {31'd0, imem_rd_en}, 32'd0);
      exp_q.delete();
      arr.delete();
      mdl_count = 0;
      mdl_fetch = START;
    end else begin
      while (arr.size() != 0 && arr[0] < cyc) begin
        void'(arr.pop_front());
        mdl_count++;
      end
      chk("fifo_count", {29'd0, fifo_count}, 32'(mdl_count));
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, mdl_count != 0});
      if (mdl_count == 0) begin
        chk("instr_out_empty", instr_out, 32'd0);
        chk("pc_out_empty", pc_out, 32'd0);
      end
      chk("imem_addr", imem_addr, mdl_fetch);
      exp_rd = !load_pc && ((mdl_count + arr.size()) < DEPTH);
      chk("imem_rd_en", {31'd0, imem_rd_en}, {31'd0, exp_rd});
      if (load_pc) begin
        base = (mdl_count != 0) ? exp_q[0].pc : mdl_fetch;
        case (sel_pc)
          2'b00:   tgt = base + 32'd4;
          2'b01:   tgt = START;
          2'b10:   tgt = branch_target;
          default: tgt = base;
        endcase
        exp_q.delete();
        arr.delete();
        mdl_count = 0;
        mdl_fetch = tgt;
      end else begin
        if (mdl_count != 0 && instr_ready) begin
          e = exp_q.pop_front();
          chk("pc_out", pc_out, e.pc);
          chk("instr_out", instr_out, e.instr);
          mdl_count--;
          pops++;
        end
        if (exp_rd) begin
          e.pc    = mdl_fetch;
          e.instr = mdl_fetch ^ KEY;
          exp_q.push_back(e);
          arr.push_back(cyc + LAT);
          mdl_fetch = mdl_fetch + 32'd4;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [1:0] s, input logic [31:0] t);
    load_pc = 1'b1;
    sel_pc = s;
    branch_target = t;
    tick(1);
    load_pc = 1'b0;
  endtask

  initial begin
    int first;
    rst = 1'b1; load_pc = 1'b0; sel_pc = 2'b00; branch_target = '0; instr_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    first = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (instr_valid) begin first = n; break; end
    end
    chk("first_valid_cycle", 32'(first), 32'd3);
    tick(8);

    // Back-pressure until the queue is full.
    instr_ready = 1'b0;
    tick(20);
    chk("stall_count", {29'd0, fifo_count}, 32'd4);
    chk("stall_no_req", {31'd0, imem_rd_en}, 32'd0);
    instr_ready = 1'b1;
    tick(10);

    // Branch redirect with a full queue.
    instr_ready = 1'b0;
    tick(8);
    redirect(2'b10, 32'h0000_0100);
    chk("flush_count", {29'd0, fifo_count}, 32'd0);
    chk("flush_addr", imem_addr, 32'h0000_0100);
    instr_ready = 1'b1;
    tick(12);

    redirect(2'b01, 32'h0);
    tick(10);
    instr_ready = 1'b0;
    tick(6);
    redirect(2'b11, 32'h0);
    instr_ready = 1'b1;
    tick(6);
    instr_ready = 1'b0;
    tick(6);
    redirect(2'b00, 32'h0);
    instr_ready = 1'b1;
    tick(8);

    // Sequential redirect with an empty queue uses fetch_pc as the base.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    redirect(2'b00, 32'h0);
    chk("empty_base_addr", imem_addr, START + 32'd4);
    tick(10);

    // Address wrap.
    redirect(2'b10, 32'hFFFF_FFF8);
    tick(10);

    // Reset mid-stream with reads in flight.
    rst = 1'b1;
    tick(1);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_addr", imem_addr, START);
    rst = 1'b0;
    tick(10);

    for (int i = 0; i < 2000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      load_pc = !rst && ($urandom_range(0, 29) == 0);
      sel_pc = 2'($urandom_range(0, 3));
      branch_target = ($urandom_range(0, 3) == 0) ?
                      (32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2)) :
                      ($urandom() & 32'hFFFF_FFFC);
      tick(1);
    end
    rst = 1'b0; load_pc = 1'b0; instr_ready = 1'b1;
    tick(10);
    chk("enough_deliveries", {31'd0, pops > 500}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
